// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared FSM state type and default pattern for the serial sequence detector
package seq_detect_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   localparam int DEF_PAT_LEN = 4;
   localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 4'b1011;
endpackage

// File: rtl/seq_window_det.sv
// seq_window_det: PAT_LEN-bit window with fill count and registered detect pulse (SEQ_DETECT_OVERLAP_EN selects overlapping matches)
module seq_window_det
   import seq_detect_pkg::*;
#(
   parameter int PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   input  logic x,
   output logic z,
   output logic hit_next
);
   localparam int FW = $clog2(PAT_LEN + 1);
   logic [PAT_LEN-1:0] win_q, win_d, win_sh;
   logic [FW-1:0] fill_q, fill_d, fill_inc;
   logic z_q, z_d;
   assign win_sh = {win_q[PAT_LEN-2:0], x};
   assign fill_inc = (fill_q == FW'(PAT_LEN)) ? fill_q : fill_q + 1'b1;
   assign hit_next = en && !clr && (win_sh == PATTERN) && (fill_inc >= FW'(PAT_LEN));
   assign z = z_q;
   // next window, fill and pulse: clear on accept, shift while enabled
   always_comb begin
      win_d = win_q;
      fill_d = fill_q;
      z_d = 1'b0;
      if (clr) begin
         win_d = '0;
         fill_d = '0;
      end else if (en) begin
         win_d = win_sh;
         z_d = hit_next;
`ifdef SEQ_DETECT_OVERLAP_EN
         fill_d = fill_inc;
`else
         fill_d = hit_next ? '0 : fill_inc;
`endif
      end
   end
   // window, fill and pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q <= '0;
         fill_q <= '0;
         z_q <= 1'b0;
      end else begin
         win_q <= win_d;
         fill_q <= fill_d;
         z_q <= z_d;
      end
   end
endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: word-to-serial controller that shifts each word MSB-first into seq_window_det and reports the per-word match count (SEQ_DETECT_OVERLAP_EN selects overlapping matches)
module seq_detect_ctrl
   import seq_detect_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int PAT_LEN = DEF_PAT_LEN,
   parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
   localparam int CNT_W = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  match_cnt,
   output logic              match_any,
   output logic              z,
   output logic              busy
);
   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   state_t state_q, state_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic clr, en, hit_next;
   seq_window_det #(.PAT_LEN(PAT_LEN), .PATTERN(PATTERN)) u_det (
      .clk(clk), .rst(rst), .clr(clr), .en(en), .x(sh_q[DATA_W-1]), .z(z), .hit_next(hit_next)
   );
   assign in_ready = state_q == IDLE;
   assign busy = state_q == SHIFT;
   assign out_valid = state_q == DONE;
   assign match_cnt = cnt_q;
   assign match_any = cnt_q != '0;
   // FSM next state, shift register, bit counter and match counter
   always_comb begin
      state_d = state_q;
      sh_d = sh_q;
      bit_d = bit_q;
      cnt_d = cnt_q;
      clr = 1'b0;
      en = 1'b0;
      case (state_q)
         IDLE: if (in_valid) begin
            sh_d = in_data;
            bit_d = '0;
            cnt_d = '0;
            clr = 1'b1;
            state_d = SHIFT;
         end
         SHIFT: begin
            en = 1'b1;
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
            bit_d = bit_q + 1'b1;
            cnt_d = hit_next ? cnt_q + 1'b1 : cnt_q;
            state_d = (bit_q == BW'(DATA_W - 1)) ? DONE : SHIFT;
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q <= '0;
         bit_q <= '0;
         cnt_q <= '0;
      end else begin
         state_q <= state_d;
         sh_q <= sh_d;
         bit_q <= bit_d;
         cnt_q <= cnt_d;
      end
   end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: self-checking bench comparing the controller against a string-scan match model
module tb_seq_detect_ctrl;
   localparam int DW = 16;
   localparam int PL = 4;
   localparam logic [PL-1:0] PAT = 4'b1011;
   localparam int CW = $clog2(DW + 1);
   logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic in_ready, out_valid, match_any, z, busy;
   logic [CW-1:0] match_cnt;
   int n_chk = 0, n_fail = 0;
   int cyc = 0;

   seq_detect_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .match_cnt(match_cnt), .match_any(match_any),
      .z(z), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // scan the word as a bit string, MSB first; ends[k] marks a match completed by bit k
   function automatic int model(input logic [DW-1:0] w, output logic [DW-1:0] ends);
      int cnt = 0;
      int last = -100;
      logic [PL-1:0] seg;
      ends = '0;
      for (int k = PL - 1; k < DW; k++) begin
         seg = w[DW-1-(k-PL+1) -: PL];
`ifdef SEQ_DETECT_OVERLAP_EN
         if (seg == PAT) begin
`else
         if (seg == PAT && k - last >= PL) begin
`endif
            cnt++;
            last = k;
            ends[k] = 1'b1;
         end
      end
      return cnt;
   endfunction

   task automatic word_check(input logic [DW-1:0] w, input string name);
      logic [DW-1:0] ends;
      int exp;
      int t;
      logic ez;
      exp = model(w, ends);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = w;
      out_ready = 1'b0;
      t = 0;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      n_chk++;
      if (!in_ready) begin
         n_fail++;
         $display("FAIL %s accept_timeout in_ready=%0b required 1", name, in_ready);
         return;
      end
      for (int c = 1; c <= DW + 1; c++) begin
         @(negedge clk);
         in_valid = 1'b0;
         ez = (c >= 2) ? ends[c-2] : 1'b0;
         n_chk++;
         if (z !== ez) begin
            n_fail++;
            $display("FAIL %s z cycle %0d got %0b required %0b", name, c, z, ez);
         end
         n_chk++;
         if (busy !== (c <= DW) || out_valid !== (c == DW + 1)) begin
            n_fail++;
            $display("FAIL %s busy/out_valid cycle %0d got %0b/%0b required %0b/%0b", name, c, busy, out_valid, c <= DW, c == DW + 1);
         end
      end
      n_chk++;
      if (match_cnt !== CW'(exp) || match_any !== (exp != 0)) begin
         n_fail++;
         $display("FAIL %s count word=%h got %0d/%0b required %0d/%0b", name, w, match_cnt, match_any, exp, exp != 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s release in_ready/out_valid got %0b/%0b required 1/0", name, in_ready, out_valid);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || z !== 1'b0 || match_cnt !== '0 || match_any !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values rdy=%0b ov=%0b busy=%0b z=%0b cnt=%0d any=%0b required 1 0 0 0 0 0", in_ready, out_valid, busy, z, match_cnt, match_any);
      end
   endtask

   task automatic test_vectors();
      int exp;
      logic [DW-1:0] e;
      exp = model(16'hB6D0, e);
      n_chk++;
`ifdef SEQ_DETECT_OVERLAP_EN
      if (exp != 3) begin
`else
      if (exp != 2) begin
`endif
         n_fail++;
         $display("FAIL model_b6d0 got %0d", exp);
      end
      word_check(16'hB000, "b000");
      word_check(16'hB6D0, "b6d0");
      word_check(16'hBBBB, "bbbb");
      word_check(16'h0000, "zero");
      word_check(16'hFFFF, "ones");
   endtask

   task automatic test_hold();
      word_check(16'hB000, "hold_pre");
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 16'hBBBB;
      while (!in_ready) @(negedge clk);
      repeat (DW + 1) @(negedge clk);
      in_data = 16'h1234;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_chk++;
         if (out_valid !== 1'b1 || match_cnt !== CW'(4) || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold cycle %0d ov/cnt/rdy got %0b/%0d/%0b required 1/4/0", i, out_valid, match_cnt, in_ready);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_chk++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_release rdy/ov got %0b/%0b required 1/0", in_ready, out_valid);
      end
      in_valid = 1'b0;
   endtask

   task automatic test_mid_reset();
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 16'hBBBB;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || match_cnt !== '0) begin
         n_fail++;
         $display("FAIL mid_reset rdy/busy/ov/cnt got %0b/%0b/%0b/%0d required 1/0/0/0", in_ready, busy, out_valid, match_cnt);
      end
      word_check(16'hB000, "after_reset");
   endtask

   task automatic test_back_to_back();
      int acc [2];
      int res [2];
      int na = 0, nr = 0;
      @(negedge clk);
      in_valid = 1'b1;
      out_ready = 1'b1;
      in_data = 16'hB000;
      for (int i = 0; i < 80 && nr < 2; i++) begin
         if (in_ready && na < 2) begin
            acc[na] = cyc;
            na++;
         end
         if (out_valid) begin
            res[nr] = int'(match_cnt);
            nr++;
         end
         @(negedge clk);
         if (na == 1) in_data = 16'hBBBB;
         if (na == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      n_chk++;
      if (na != 2 || nr != 2) begin
         n_fail++;
         $display("FAIL b2b_timeout accepts/results got %0d/%0d required 2/2", na, nr);
      end else begin
         n_chk++;
         if (acc[1] - acc[0] != DW + 2) begin
            n_fail++;
            $display("FAIL b2b_period got %0d required %0d", acc[1] - acc[0], DW + 2);
         end
         n_chk++;
         if (res[0] != 1 || res[1] != 4) begin
            n_fail++;
            $display("FAIL b2b_results got %0d,%0d required 1,4", res[0], res[1]);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 25; i++) word_check(DW'($urandom), "random");
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_hold();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
